// File: rtl/mux7_pkg.sv
// Shared constants and data type for the mux7 block.
// The defaults here also set the parameter defaults on mux7 and mux2_w.
package mux7_pkg;

  localparam int WIDTH_DEF = 7;
  localparam int CNT_W_DEF = 8;

  typedef logic [WIDTH_DEF-1:0] data_t;

endpackage

// File: rtl/mux2_w.sv
// Two-input combinational selector of WIDTH bits.
// There is no storage in this module, so no latch can be inferred.
module mux2_w
  import mux7_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             select,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  output logic [WIDTH-1:0] b
);

  assign b = select ? a1 : a0;

endmodule

// File: rtl/mux7.sv
// Width-parameterised 2:1 mux with a registered copy, parity and a select-toggle counter.
// Every register uses a synchronous active-low reset that overrides en and toggle counting.
module mux7
  import mux7_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             select,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic             en,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] b_q,
  output logic             sel_q,
  output logic             parity_q,
  output logic [CNT_W-1:0] sel_toggles
);

  logic sel_prev;
  logic sel_change;
  logic cnt_full;

  mux2_w #(.WIDTH(WIDTH)) u_mux (
    .select (select),
    .a0     (a0),
    .a1     (a1),
    .b      (b)
  );

  assign sel_change = (select != sel_prev);
  assign cnt_full   = (sel_toggles == {CNT_W{1'b1}});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      b_q      <= '0;
      sel_q    <= 1'b0;
      parity_q <= 1'b0;
    end else if (en) begin
      b_q      <= b;
      sel_q    <= select;
      parity_q <= ^b;
    end
  end

  // sel_prev tracks select every cycle, independent of en
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_prev    <= 1'b0;
      sel_toggles <= '0;
    end else begin
      sel_prev <= select;
      if (sel_change && !cnt_full) begin
        sel_toggles <= sel_toggles + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mux7.sv
// Directed self-checking bench for mux7: vector table plus hand-written
// sequences for toggle counting, saturation and mid-run reset.
module tb_mux7;
  import mux7_pkg::*;

  localparam int WIDTH = 7;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             select;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] a1;
  logic             en;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] b_q;
  logic             sel_q;
  logic             parity_q;
  logic [CNT_W-1:0] sel_toggles;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic             sel;
    logic [WIDTH-1:0] va0;
    logic [WIDTH-1:0] va1;
    logic             ven;
    logic [WIDTH-1:0] exp_b;
    logic [WIDTH-1:0] exp_bq;
    logic             exp_selq;
    logic             exp_par;
  } vec_t;

  vec_t vecs[8];

  mux7 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .select      (select),
    .a0          (a0),
    .a1          (a1),
    .en          (en),
    .b           (b),
    .b_q         (b_q),
    .sel_q       (sel_q),
    .parity_q    (parity_q),
    .sel_toggles (sel_toggles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // advance one rising edge, then settle 1 time unit
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{1'b0, 7'h01, 7'h7E, 1'b1, 7'h01, 7'h01, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 7'h01, 7'h7E, 1'b1, 7'h7E, 7'h7E, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 7'h00, 7'h13, 1'b0, 7'h13, 7'h7E, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 7'h07, 7'h13, 1'b1, 7'h07, 7'h07, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 7'h00, 7'h7F, 1'b1, 7'h00, 7'h00, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 7'h00, 7'h7F, 1'b1, 7'h7F, 7'h7F, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 7'h40, 7'h7F, 1'b0, 7'h40, 7'h7F, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 7'h40, 7'h7F, 1'b1, 7'h40, 7'h40, 1'b0, 1'b1};

    rst_n  = 1'b0;
    select = 1'b0;
    a0     = 7'h2A;
    a1     = 7'h11;
    en     = 1'b1;
    cyc();
    cyc();
    chk("reset_b_q", 32'(b_q), 32'h0);
    chk("reset_sel_q", 32'(sel_q), 32'h0);
    chk("reset_parity_q", 32'(parity_q), 32'h0);
    chk("reset_toggles", 32'(sel_toggles), 32'h0);
    chk("b_during_reset", 32'(b), 32'h2A);

    rst_n = 1'b1;
    a0    = 7'b1010101;
    a1    = 7'b0101000;
    #1;
    chk("sel0_b", 32'(b), 32'h55);
    cyc();
    chk("sel0_b_q", 32'(b_q), 32'h55);

    select = 1'b1;
    #1;
    chk("sel1_b_comb", 32'(b), 32'h28);
    cyc();
    chk("sel1_b_q", 32'(b_q), 32'h28);
    chk("sel1_sel_q", 32'(sel_q), 32'h1);
    chk("sel1_parity_q", 32'(parity_q), 32'h0);
    chk("first_toggle", 32'(sel_toggles), 32'h1);
    for (int i = 0; i < 49; i++) cyc();
    select = 1'b0;
    #1;
    chk("sel_back_b", 32'(b), 32'h55);
    cyc();
    chk("two_toggles", 32'(sel_toggles), 32'h2);

    en = 1'b0;
    a0 = 7'h7F;
    #1;
    chk("en0_b", 32'(b), 32'h7F);
    cyc();
    chk("en0_b_q_hold", 32'(b_q), 32'h55);
    chk("en0_sel_q_hold", 32'(sel_q), 32'h0);

    for (int i = 0; i < 8; i++) begin
      select = vecs[i].sel;
      a0     = vecs[i].va0;
      a1     = vecs[i].va1;
      en     = vecs[i].ven;
      #1;
      chk($sformatf("vec%0d_b", i), 32'(b), 32'(vecs[i].exp_b));
      cyc();
      chk($sformatf("vec%0d_b_q", i), 32'(b_q), 32'(vecs[i].exp_bq));
      chk($sformatf("vec%0d_sel_q", i), 32'(sel_q), 32'(vecs[i].exp_selq));
      chk($sformatf("vec%0d_parity_q", i), 32'(parity_q), 32'(vecs[i].exp_par));
    end
    chk("table_toggles", 32'(sel_toggles), 32'h6);

    // 248 more toggles reach 254, one more reaches the ceiling
    for (int i = 0; i < 248; i++) begin
      select = ~select;
      cyc();
    end
    chk("toggles_254", 32'(sel_toggles), 32'hFE);
    select = ~select;
    cyc();
    chk("toggles_255", 32'(sel_toggles), 32'hFF);
    for (int i = 0; i < 300; i++) begin
      select = ~select;
      cyc();
    end
    chk("toggles_saturated", 32'(sel_toggles), 32'hFF);

    en     = 1'b1;
    select = 1'b1;
    a0     = 7'h0F;
    a1     = 7'h3C;
    cyc();
    chk("pre_reset_b_q", 32'(b_q), 32'h3C);
    rst_n = 1'b0;
    a1    = 7'h5A;
    #1;
    chk("reset_b_tracks", 32'(b), 32'h5A);
    cyc();
    chk("midreset_b_q", 32'(b_q), 32'h0);
    chk("midreset_sel_q", 32'(sel_q), 32'h0);
    chk("midreset_parity_q", 32'(parity_q), 32'h0);
    chk("midreset_toggles", 32'(sel_toggles), 32'h0);
    chk("midreset_b", 32'(b), 32'h5A);

    rst_n = 1'b1;
    cyc();
    chk("post_reset_toggle", 32'(sel_toggles), 32'h1);
    chk("post_reset_b_q", 32'(b_q), 32'h5A);
    chk("post_reset_parity_q", 32'(parity_q), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux7.md
MUX7 -- requirements
Module: mux7

Interface
REQ-001 Parameter WIDTH, default 7, is the data width of a0, a1, b and b_q; this block is only required to work at 7.
REQ-002 Parameter CNT_W, default 8, is the width of sel_toggles.
REQ-003 Clocking: one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all registers.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 select  input  1  0 selects a0; 1 selects a1.
REQ-007 a0  input  WIDTH  data input chosen when select=0.
REQ-008 a1  input  WIDTH  data input chosen when select=1.
REQ-009 en  input  1  capture enable for the registered output path.
REQ-010 b  output  WIDTH  combinational mux result.
REQ-011 b_q  output  WIDTH  registered mux result.
REQ-012 sel_q  output  1  registered select, captured together with b_q.
REQ-013 parity_q  output  1  registered even-parity bit (XOR reduction) of b_q.
REQ-014 sel_toggles  output  CNT_W  saturating count of select transitions since reset.

Function
REQ-015 b SHALL equal a0 when select=0 and a1 when select=1, purely combinationally, with zero-cycle latency and independent of clk, rst_n and en.
REQ-016 b SHALL follow any change on select, a0 or a1 within the same delta or cycle, with no latch inferred.
REQ-017 When rst_n=1 and en=1 at a rising clk edge, b_q, sel_q and parity_q SHALL load b, select and ^b respectively, giving one-cycle latency.
REQ-018 When rst_n=1 and en=0, b_q, sel_q and parity_q SHALL hold their values.
REQ-019 An internal sel_prev register SHALL capture select on every rising edge while rst_n=1, regardless of en.
REQ-020 sel_toggles SHALL increment by 1 on each edge where select != sel_prev and rst_n=1.
REQ-021 sel_toggles SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-022 A select value of X or Z is not required to be handled; b is don't-care in that case.

Reset
REQ-023 On a rising clk edge with rst_n=0, b_q, sel_q, parity_q, sel_prev and sel_toggles SHALL all become 0.
REQ-024 Reset SHALL take priority over en and over toggle counting.
REQ-025 Asserting reset mid-operation SHALL clear these registers on the next edge only; b SHALL be unaffected by reset.
REQ-026 No asynchronous reset path is permitted.

Structure
REQ-027 Package mux7_pkg SHALL hold the WIDTH and CNT_W default constants and a data type of width WIDTH.
REQ-028 The combinational selector SHALL be one sub-module, mux2_w, parameterised by WIDTH.
REQ-029 mux7 SHALL instantiate mux2_w once and contain the registers, parity and toggle counter.

Verification
REQ-030 Drive select=0, a0=7'b1010101, a1=7'b0101000 -> b=7'b1010101 immediately.
REQ-031 With the same data, set select=1 -> b=7'b0101000 in the same cycle; with en=1, b_q=7'b0101000 and sel_q=1 after one edge; parity_q=0.
REQ-032 Set select=1 for 50 cycles, then select=0 -> sel_toggles=2 counted from reset, including the initial 0->1 change; b returns to 7'b1010101.
REQ-033 Hold en=0 while changing a0 to 7'h7F and select to 0 -> b=7'h7F, and b_q keeps its previous value.
REQ-034 Toggle select every cycle for 300 cycles -> sel_toggles sticks at 8'hFF.
REQ-035 Assert rst_n=0 for one edge mid-run -> b_q, sel_q, parity_q and sel_toggles read 0 after that edge, while b still tracks its inputs.
